// File: rtl/usbfs_link_pkg.sv
// Shared types for the usbfs link-state controller: link states, decoded line
// states and the per-state output pattern.
package usbfs_link_pkg;

  typedef enum logic [2:0] {
    DISC    = 3'd0,
    BUSRST  = 3'd1,
    ACTIVE  = 3'd2,
    SUSPEND = 3'd3,
    RWAKE   = 3'd4
  } link_state_t;

  typedef enum logic [1:0] {
    SE0 = 2'd0,
    J   = 2'd1,
    K   = 2'd2
  } line_t;

  typedef struct packed {
    logic dp_pull;
    logic usb_rstn;
    logic suspend;
    logic wk_oe;
    logic wk_dp;
    logic wk_dn;
  } link_out_t;

  // Output pattern owned by each link state; registered by the controller.
  function automatic link_out_t state_outputs(input link_state_t s);
    link_out_t o;
    o = '0;
    case (s)
      DISC:    o = '0;
      BUSRST:  o.dp_pull = 1'b1;
      ACTIVE: begin
        o.dp_pull  = 1'b1;
        o.usb_rstn = 1'b1;
      end
      SUSPEND: begin
        o.dp_pull  = 1'b1;
        o.usb_rstn = 1'b1;
        o.suspend  = 1'b1;
      end
      RWAKE: begin
        o.dp_pull  = 1'b1;
        o.usb_rstn = 1'b1;
        o.wk_oe    = 1'b1;
        o.wk_dn    = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Saturating increment: holds at term once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] term);
    return (v >= term) ? term : v + 32'd1;
  endfunction

endpackage

// File: rtl/usbfs_line_sync.sv
// Two-flop synchronizer for the raw D+/D- pins plus decode to a line state.
// SE1 is folded into J so downstream logic only ever sees SE0, J or K.
module usbfs_line_sync
  import usbfs_link_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  dp_rx,
  input  logic  dn_rx,
  output line_t line
);

  logic [1:0] dp_sync;
  logic [1:0] dn_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_sync <= '0;
      dn_sync <= '0;
    end else begin
      dp_sync <= {dp_sync[0], dp_rx};
      dn_sync <= {dn_sync[0], dn_rx};
    end
  end

  always_comb begin
    line = J;
    if (!dp_sync[1] && !dn_sync[1]) line = SE0;
    else if (!dp_sync[1] && dn_sync[1]) line = K;
  end

endmodule

// File: rtl/usbfs_link_ctrl.sv
// USB FS connection/link-state controller: pull-up, connect delay, bus reset,
// suspend, host resume and device remote-wakeup signalling.
module usbfs_link_ctrl
  import usbfs_link_pkg::*;
#(
  parameter int CONNECT_CYCLES = 60000000,
  parameter int BUSRST_CYCLES  = 300,
  parameter int SUSPEND_CYCLES = 180000,
  parameter int RWAKE_CYCLES   = 120000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       usb_dp_rx,
  input  logic       usb_dn_rx,
  input  logic       core_oe,
  input  logic       soft_connect,
  input  logic       rwake_req,
  output logic       usb_dp_pull,
  output logic       usb_rstn,
  output logic       usb_suspend,
  output logic       wk_oe,
  output logic       wk_dp,
  output logic       wk_dn,
  output logic [2:0] link_state
);

  localparam logic [31:0] CONNECT_TERM = 32'(CONNECT_CYCLES - 1);
  localparam logic [31:0] BUSRST_TERM  = 32'(BUSRST_CYCLES - 1);
  localparam logic [31:0] SUSPEND_TERM = 32'(SUSPEND_CYCLES - 1);
  localparam logic [31:0] RWAKE_TERM   = 32'(RWAKE_CYCLES - 1);

  line_t       line;
  link_state_t state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [31:0] se0_cnt, se0_nx;
  logic [31:0] idle_cnt, idle_nx;
  link_out_t   out_q;

  usbfs_line_sync u_line_sync (
    .clk   (clk),
    .rstn  (rstn),
    .dp_rx (usb_dp_rx),
    .dn_rx (usb_dn_rx),
    .line  (line)
  );

  // cnt serves the connect delay in DISC and the K duration in RWAKE;
  // the two never overlap, and every state change clears all counters.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    se0_nx   = se0_cnt;
    idle_nx  = idle_cnt;
    if (!soft_connect) begin
      state_nx = DISC;
      cnt_nx   = '0;
      se0_nx   = '0;
      idle_nx  = '0;
    end else begin
      case (state)
        DISC: begin
          if (cnt == CONNECT_TERM) state_nx = BUSRST;
          else cnt_nx = sat_inc(cnt, CONNECT_TERM);
        end
        BUSRST: begin
          if (line != SE0) state_nx = ACTIVE;
        end
        ACTIVE: begin
          se0_nx  = (line == SE0) ? sat_inc(se0_cnt, BUSRST_TERM) : '0;
          idle_nx = (line == J && !core_oe) ? sat_inc(idle_cnt, SUSPEND_TERM) : '0;
          if (line == SE0 && se0_cnt == BUSRST_TERM) state_nx = BUSRST;
          else if (line == J && !core_oe && idle_cnt == SUSPEND_TERM) state_nx = SUSPEND;
        end
        SUSPEND: begin
          se0_nx = (line == SE0) ? sat_inc(se0_cnt, BUSRST_TERM) : '0;
          if (line == SE0 && se0_cnt == BUSRST_TERM) state_nx = BUSRST;
          else if (line == K) state_nx = ACTIVE;
          else if (rwake_req) state_nx = RWAKE;
        end
        RWAKE: begin
          // The device owns the bus here, so the line is not looked at.
          if (cnt == RWAKE_TERM) state_nx = ACTIVE;
          else cnt_nx = sat_inc(cnt, RWAKE_TERM);
        end
        default: state_nx = DISC;
      endcase
      if (state_nx != state) begin
        cnt_nx  = '0;
        se0_nx  = '0;
        idle_nx = '0;
      end
    end
  end

  // Outputs are registered from the next state so they move on the same edge
  // as link_state; the async reset releases the bus immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= DISC;
      cnt      <= '0;
      se0_cnt  <= '0;
      idle_cnt <= '0;
      out_q    <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      se0_cnt  <= se0_nx;
      idle_cnt <= idle_nx;
      out_q    <= state_outputs(state_nx);
    end
  end

  assign usb_dp_pull = out_q.dp_pull;
  assign usb_rstn    = out_q.usb_rstn;
  assign usb_suspend = out_q.suspend;
  assign wk_oe       = out_q.wk_oe;
  assign wk_dp       = out_q.wk_dp;
  assign wk_dn       = out_q.wk_dn;
  assign link_state  = state;

endmodule

// File: tb/tb_usbfs_link_ctrl.sv
// Bench for usbfs_link_ctrl: directed link scenarios plus a randomized line
// phase, every cycle checked against a run-length reference model.
module tb_usbfs_link_ctrl;

  localparam int CONN = 100;
  localparam int BRST = 10;
  localparam int SUSP = 50;
  localparam int RWK  = 20;

  localparam int S_DISC    = 0;
  localparam int S_BUSRST  = 1;
  localparam int S_ACTIVE  = 2;
  localparam int S_SUSPEND = 3;
  localparam int S_RWAKE   = 4;

  localparam int L_SE0 = 0;
  localparam int L_J   = 1;
  localparam int L_K   = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dp = 1'b0;
  logic       dn = 1'b0;
  logic       core_oe = 1'b0;
  logic       soft_connect = 1'b0;
  logic       rwake_req = 1'b0;
  logic       usb_dp_pull, usb_rstn, usb_suspend, wk_oe, wk_dp, wk_dn;
  logic [2:0] link_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: link state, run lengths of the current conditions and a
  // two-deep history of pin line states standing in for the synchronizer.
  int m_state;
  int m_conn, m_se0, m_idle, m_rw;
  int pipe[$];

  always #5 clk = ~clk;

  usbfs_link_ctrl #(
    .CONNECT_CYCLES (CONN),
    .BUSRST_CYCLES  (BRST),
    .SUSPEND_CYCLES (SUSP),
    .RWAKE_CYCLES   (RWK)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .usb_dp_rx    (dp),
    .usb_dn_rx    (dn),
    .core_oe      (core_oe),
    .soft_connect (soft_connect),
    .rwake_req    (rwake_req),
    .usb_dp_pull  (usb_dp_pull),
    .usb_rstn     (usb_rstn),
    .usb_suspend  (usb_suspend),
    .wk_oe        (wk_oe),
    .wk_dp        (wk_dp),
    .wk_dn        (wk_dn),
    .link_state   (link_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic p, input logic n);
    if (p) return L_J;
    if (n) return L_K;
    return L_SE0;
  endfunction

  function automatic logic [8:0] exp_vec(input int s);
    case (s)
      S_DISC:    return 9'b0;
      S_BUSRST:  return {6'b100000, 3'd1};
      S_ACTIVE:  return {6'b110000, 3'd2};
      S_SUSPEND: return {6'b111000, 3'd3};
      S_RWAKE:   return {6'b110101, 3'd4};
      default:   return 9'h1ff;
    endcase
  endfunction

  function automatic logic [8:0] obs_vec();
    return {usb_dp_pull, usb_rstn, usb_suspend, wk_oe, wk_dp, wk_dn, link_state};
  endfunction

  task automatic go(input int s);
    m_state = s;
    m_conn  = 0;
    m_se0   = 0;
    m_idle  = 0;
    m_rw    = 0;
  endtask

  task automatic model_reset();
    go(S_DISC);
    pipe = {};
    pipe.push_back(L_SE0);
    pipe.push_back(L_SE0);
  endtask

  task automatic model_edge();
    int ln;
    ln = pipe[0];
    void'(pipe.pop_front());
    pipe.push_back(line_of(dp, dn));
    if (!soft_connect) begin
      go(S_DISC);
      return;
    end
    case (m_state)
      S_DISC: begin
        m_conn++;
        if (m_conn == CONN) go(S_BUSRST);
      end
      S_BUSRST: if (ln != L_SE0) go(S_ACTIVE);
      S_ACTIVE: begin
        m_se0  = (ln == L_SE0) ? m_se0 + 1 : 0;
        m_idle = (ln == L_J && !core_oe) ? m_idle + 1 : 0;
        if (m_se0 == BRST) go(S_BUSRST);
        else if (m_idle == SUSP) go(S_SUSPEND);
      end
      S_SUSPEND: begin
        m_se0 = (ln == L_SE0) ? m_se0 + 1 : 0;
        if (m_se0 == BRST) go(S_BUSRST);
        else if (ln == L_K) go(S_ACTIVE);
        else if (rwake_req) go(S_RWAKE);
      end
      S_RWAKE: begin
        m_rw++;
        if (m_rw == RWK) go(S_ACTIVE);
      end
      default: go(S_DISC);
    endcase
  endtask

  // Drives inputs between edges, advances one clock, checks all outputs.
  task automatic step(input logic i_dp, input logic i_dn, input logic i_oe,
                      input logic i_sc, input logic i_rw);
    dp           = i_dp;
    dn           = i_dn;
    core_oe      = i_oe;
    soft_connect = i_sc;
    rwake_req    = i_rw;
    @(posedge clk);
    model_edge();
    #1;
    chk("track", 32'(obs_vec()), 32'(exp_vec(m_state)));
  endtask

  task automatic drive(input int ln, input logic oe, input logic rw);
    step(ln == L_J, ln == L_K, oe, 1'b1, rw);
  endtask

  task automatic run(input int ln, input int n);
    for (int i = 0; i < n; i++) drive(ln, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int ln;
    int len;
    logic oe, rw, sc;

    // Reset
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vec", 32'(obs_vec()), 32'd0);
    rstn = 1'b1;
    model_reset();

    // Attach
    n = 0;
    while (n < 200 && usb_dp_pull !== 1'b1) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("attach_delay", n, CONN);
    chk("attach_rstn_low", 32'(usb_rstn), 32'd0);
    n = 0;
    while (n < 10 && usb_rstn !== 1'b1) begin
      run(L_J, 1);
      n++;
    end
    chk("attach_active_lat", n, 3);
    chk("attach_state", 32'(link_state), 32'd2);

    // Bus reset
    run(L_SE0, 9);
    run(L_J, 3);
    chk("busrst_9_stays", 32'(link_state), 32'd2);
    run(L_SE0, 11);
    chk("busrst_10_pre", 32'(link_state), 32'd2);
    run(L_SE0, 1);
    chk("busrst_10_state", 32'(link_state), 32'd1);
    chk("busrst_rstn", 32'(usb_rstn), 32'd0);
    run(L_J, 3);
    chk("busrst_exit", 32'(link_state), 32'd2);

    // Suspend with a core_oe pulse restarting the idle count
    run(L_J, 40);
    drive(L_J, 1'b1, 1'b0);
    n = 0;
    while (n < 100 && usb_suspend !== 1'b1) begin
      run(L_J, 1);
      n++;
    end
    chk("suspend_after_oe", n, SUSP);
    chk("suspend_state", 32'(link_state), 32'd3);

    // Host resume
    run(L_K, 3);
    chk("resume_state", 32'(link_state), 32'd2);
    chk("resume_susp", 32'(usb_suspend), 32'd0);

    // rwake_req outside SUSPEND
    for (int i = 0; i < 3; i++) drive(L_J, 1'b0, 1'b1);
    chk("rwake_ignored", 32'(link_state), 32'd2);

    // Remote wakeup
    n = 0;
    while (n < 100 && usb_suspend !== 1'b1) begin
      run(L_J, 1);
      n++;
    end
    chk("resuspend", 32'(usb_suspend), 32'd1);
    drive(L_J, 1'b0, 1'b1);
    chk("rwake_enter", 32'({wk_oe, wk_dp, wk_dn}), 32'b101);
    n = 1;
    m = 0;
    while (m < 60 && wk_oe === 1'b1) begin
      run(L_J, 1);
      m++;
      if (wk_oe === 1'b1) n++;
    end
    chk("rwake_len", n, RWK);
    chk("rwake_exit_state", 32'(link_state), 32'd2);

    // Soft disconnect and reattach
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disc_pull", 32'(usb_dp_pull), 32'd0);
    chk("disc_rstn", 32'(usb_rstn), 32'd0);
    chk("disc_state", 32'(link_state), 32'd0);
    n = 0;
    while (n < 200 && usb_dp_pull !== 1'b1) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("reattach_delay", n, CONN);

    // Randomized line segments
    for (int seg = 0; seg < 120; seg++) begin
      ln  = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 70));
      for (int i = 0; i < len; i++) begin
        oe = ($urandom_range(0, 59) == 0);
        rw = ($urandom_range(0, 24) == 0);
        sc = ($urandom_range(0, 399) != 0);
        step(ln == L_J, ln == L_K, oe, sc, rw);
      end
    end

    // Async reset during remote wakeup
    n = 0;
    while (n < 400 && usb_suspend !== 1'b1) begin
      run(L_J, 1);
      n++;
    end
    chk("reach_suspend", 32'(usb_suspend), 32'd1);
    drive(L_J, 1'b0, 1'b1);
    chk("rwake2_oe", 32'(wk_oe), 32'd1);
    run(L_J, 5);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_vec", 32'(obs_vec()), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("async_rst_hold", 32'(obs_vec()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
